nes_poll_scheduler: RTL
=======================

// Module: nes_poll_scheduler
// PURPOSE
//  Sequences polling of two NES controller ports. Each poll drives the shared latch line,
//  then clocks eight button bits out of each controller, port 0 first. The serial data is
//  deserialised into stable active-high button bytes, with a one-cycle frame strobe and
//  per-port new-press masks. Sits between the controller pins and the game/decoder logic.
//  Replaces free-running per-port shift capture with one scheduled, phase-aligned transaction.
// PARAMETERS
//  TICK_DIV           300   clk cycles per bus tick (6 us @ 50 MHz); legal range >= 4
//  POLL_PERIOD_TICKS  2778  ticks between automatic poll starts (~16.7 ms); >= 40
// PORTS
//  clk           in   1  system clock
//  reset         in   1  asynchronous, active-high reset
//  enable        in   1  1 = automatic periodic polling on
//  poll_req      in   1  one-cycle request for an immediate poll
//  nes_data      in   2  serial data from ports [1:0]; active-low, asynchronous
//  nes_latch     out  1  shared latch to both controllers
//  nes_clk       out  2  per-port shift clock, idle low
//  buttons0      out  8  port 0 buttons, active high: [7]A [6]B [5]Sel [4]Start [3]Up [2]Dn [1]L [0]R
//  buttons1      out  8  port 1 buttons, same bit order as buttons0
//  new_press0    out  8  buttons0 bits that went 0->1 this frame; valid with frame_valid only
//  new_press1    out  8  buttons1 bits that went 0->1 this frame; valid with frame_valid only
//  frame_valid   out  1  one-cycle strobe; new buttons*/new_press* are presented this cycle
//  busy          out  1  1 from poll start through the DONE cycle
// BEHAVIOUR
//  Reset: every output 0, state IDLE, all counters 0, pending flag 0, sync flops 1 (released).
//  nes_data goes through a 2-flop synchroniser per bit before use.
//  Tick: tick_cnt counts 0..TICK_DIV-1 only while busy; tick = (tick_cnt==TICK_DIV-1).
//   tick_cnt is cleared on entry to LATCH, so bus phases are aligned to the poll start.
//  Period counter: runs in every state while enable=1, +1 per TICK_DIV clks.
//   At POLL_PERIOD_TICKS-1 it wraps to 0 and sets pending. Held at 0 while enable=0.
//  poll_req sets pending. pending is cleared when LATCH is entered.
//   A request made while busy is serviced right after DONE; multiple requests merge into one.
//  FSM (port p in 0..1, bit k in 0..7):
//   IDLE   : pending -> LATCH.
//   LATCH  : nes_latch=1 for 2 ticks. Then p=0, k=0, -> SAMPLE.
//   SAMPLE : all outputs low for 1 tick. On its final cycle, shift ~sync[p] into port-p shadow
//            reg at LSB (shift left). After 8 samples bit 7 = first bit (A). Then -> PULSE.
//   PULSE  : nes_clk[p]=1 for 1 tick, then k++.
//            k wraps 8->0: p++; p==2 -> DONE; otherwise -> SAMPLE.
//   DONE   : 1 clk. buttonsN <= shadowN; new_pressN = shadowN & ~old buttonsN; frame_valid=1.
//            Then -> LATCH if pending, else IDLE.
//  Timing: LATCH entry to DONE = 34*TICK_DIV clks. frame_valid occurs in the cycle after the
//   final PULSE tick. busy is high from LATCH entry through DONE.
//  buttons*/new_press* hold their values between frames. new_press* read 0 outside frame_valid.
//  enable falling mid-poll: current poll completes normally. Only future automatic polls stop.
//  Reset mid-poll: nes_latch/nes_clk drop asynchronously, partial shadow data is discarded,
//   outputs show 0.
//  Output mux: nes_latch and nes_clk are registered outputs. No two of them are ever high in the
//   same cycle.
// TESTING (TICK_DIV=4, POLL_PERIOD_TICKS=50 unless noted)
//  1 Reset, enable=0, single poll_req: latch high exactly 8 clks. Then 8 nes_clk[0] pulses, then
//    8 nes_clk[1] pulses, 4 clks each. frame_valid 136 clks after LATCH entry. busy 0 afterwards.
//  2 Port0 serial 0,1,1,1,1,1,1,0 (A and Right pressed, active low); port1 all 1:
//    buttons0=8'h81, buttons1=8'h00, new_press0=8'h81 on frame_valid.
//  3 Same inputs polled twice: second frame_valid gives new_press0=8'h00, buttons0 still 8'h81.
//  4 enable=1, no requests: latch rising edges exactly 50*4=200 clks apart across 3 frames.
//  5 poll_req pulsed 3 times during a busy poll: exactly one extra poll follows. LATCH re-entered
//    the cycle after DONE.
//  6 Async reset asserted mid-PULSE of port 1: nes_clk, nes_latch, buttons*, busy all 0 same
//    cycle. After release, no poll runs until a poll_req or the period expires.

Source files
------------

// File: rtl/nes_poll_scheduler.sv
// Scheduled poller for two NES controller ports: one latch pulse, then eight shift
// clocks per port (port 0 first), deserialised into active-high button bytes.
module nes_poll_scheduler #(
    parameter int TICK_DIV          = 300,
    parameter int POLL_PERIOD_TICKS = 2778
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       poll_req,
    input  logic [1:0] nes_data,
    output logic       nes_latch,
    output logic [1:0] nes_clk,
    output logic [7:0] buttons0,
    output logic [7:0] buttons1,
    output logic [7:0] new_press0,
    output logic [7:0] new_press1,
    output logic       frame_valid,
    output logic       busy
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PW = (POLL_PERIOD_TICKS > 1) ? $clog2(POLL_PERIOD_TICKS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_PULSE  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t        state_r, state_s;
    logic [TW-1:0] tick_cnt_r;
    logic [TW-1:0] div_cnt_r;
    logic [PW-1:0] per_cnt_r;
    logic          lat_cnt_r, lat_cnt_s;
    logic          port_r, port_s;
    logic [2:0]    bit_r, bit_s;
    logic [7:0]    shadow0_r, shadow1_r;
    logic [1:0]    sync_a_r, sync_b_r;
    logic          pending_r;
    logic          tick_s, latch_entry_s, sample_s, period_wrap_s;

    assign tick_s        = (state_r != ST_IDLE) && (tick_cnt_r == TW'(TICK_DIV - 1));
    assign latch_entry_s = (state_s == ST_LATCH) && (state_r != ST_LATCH);
    assign sample_s      = (state_r == ST_SAMPLE) && tick_s;
    assign period_wrap_s = enable && (div_cnt_r == TW'(TICK_DIV - 1))
                           && (per_cnt_r == PW'(POLL_PERIOD_TICKS - 1));

    // Two-flop synchroniser; idles at 1 (released, nothing pressed)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a_r <= 2'b11;
            sync_b_r <= 2'b11;
        end else begin
            sync_a_r <= nes_data;
            sync_b_r <= sync_a_r;
        end
    end

    // Bus tick counter, realigned to every poll start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_r <= '0;
        end else if (latch_entry_s || (state_r == ST_IDLE) || tick_s) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
        end
    end

    // Free-running period timer for automatic polls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_r <= '0;
            per_cnt_r <= '0;
        end else if (!enable) begin
            div_cnt_r <= '0;
            per_cnt_r <= '0;
        end else if (div_cnt_r == TW'(TICK_DIV - 1)) begin
            div_cnt_r <= '0;
            per_cnt_r <= period_wrap_s ? '0 : per_cnt_r + PW'(1);
        end else begin
            div_cnt_r <= div_cnt_r + TW'(1);
        end
    end

    // Pending request flag; requests arriving before LATCH entry merge into one poll
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_r <= 1'b0;
        end else if (latch_entry_s) begin
            pending_r <= 1'b0;
        end else if (poll_req || period_wrap_s) begin
            pending_r <= 1'b1;
        end else begin
            pending_r <= pending_r;
        end
    end

    // FSM state and bit/port position registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            lat_cnt_r <= 1'b0;
            port_r    <= 1'b0;
            bit_r     <= 3'd0;
        end else begin
            state_r   <= state_s;
            lat_cnt_r <= lat_cnt_s;
            port_r    <= port_s;
            bit_r     <= bit_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s   = state_r;
        lat_cnt_s = lat_cnt_r;
        port_s    = port_r;
        bit_s     = bit_r;
        case (state_r)
            ST_IDLE: begin
                if (pending_r) state_s = ST_LATCH;
                else           state_s = ST_IDLE;
            end
            ST_LATCH: begin
                if (tick_s && lat_cnt_r) begin
                    state_s   = ST_SAMPLE;
                    lat_cnt_s = 1'b0;
                    port_s    = 1'b0;
                    bit_s     = 3'd0;
                end else if (tick_s) begin
                    lat_cnt_s = 1'b1;
                end else begin
                    lat_cnt_s = lat_cnt_r;
                end
            end
            ST_SAMPLE: begin
                if (tick_s) state_s = ST_PULSE;
                else        state_s = ST_SAMPLE;
            end
            ST_PULSE: begin
                if (tick_s && (bit_r == 3'd7)) begin
                    bit_s = 3'd0;
                    if (port_r) begin
                        state_s = ST_DONE;
                    end else begin
                        port_s  = 1'b1;
                        state_s = ST_SAMPLE;
                    end
                end else if (tick_s) begin
                    bit_s   = bit_r + 3'd1;
                    state_s = ST_SAMPLE;
                end else begin
                    state_s = ST_PULSE;
                end
            end
            ST_DONE: begin
                if (pending_r) state_s = ST_LATCH;
                else           state_s = ST_IDLE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Shadow shift registers: first bit received (A) ends up in bit 7
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow0_r <= 8'h00;
            shadow1_r <= 8'h00;
        end else if (sample_s && !port_r) begin
            shadow0_r <= {shadow0_r[6:0], ~sync_b_r[0]};
        end else if (sample_s && port_r) begin
            shadow1_r <= {shadow1_r[6:0], ~sync_b_r[1]};
        end
    end

    // Registered outputs, decoded from the next state so they align with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nes_latch   <= 1'b0;
            nes_clk     <= 2'b00;
            busy        <= 1'b0;
            frame_valid <= 1'b0;
            buttons0    <= 8'h00;
            buttons1    <= 8'h00;
            new_press0  <= 8'h00;
            new_press1  <= 8'h00;
        end else begin
            nes_latch   <= (state_s == ST_LATCH);
            nes_clk[0]  <= (state_s == ST_PULSE) && !port_s;
            nes_clk[1]  <= (state_s == ST_PULSE) && port_s;
            busy        <= (state_s != ST_IDLE);
            frame_valid <= (state_s == ST_DONE);
            if (state_s == ST_DONE) begin
                buttons0   <= shadow0_r;
                buttons1   <= shadow1_r;
                new_press0 <= shadow0_r & ~buttons0;
                new_press1 <= shadow1_r & ~buttons1;
            end else begin
                new_press0 <= 8'h00;
                new_press1 <= 8'h00;
            end
        end
    end

endmodule
